queue_controller: RTL and testbench
===================================

QUEUE_CONTROLLER -- requirements
Module: queue_controller

Interface
REQ-001 Parameter: CNT_WIDTH, default 8, width of the push_count and pop_count statistics counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 push_req  input  1  level request to enqueue; held high until push_ack.
REQ-005 pop_req  input  1  level request to dequeue; held high until pop_ack.
REQ-006 underflow  input  1  datapath status: queue empty (counter == 0).
REQ-007 overflow  input  1  datapath status: queue full (counter all ones).
REQ-008 add, remove, update, op_select, we, re  output  1 each  datapath controls; op_select 0 = tail/increment, 1 = head/decrement.
REQ-009 push_ack, pop_ack  output  1 each  one-cycle completion pulses.
REQ-010 push_err, pop_err  output  1 each  one-cycle rejection pulses.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 push_count, pop_count  output  CNT_WIDTH each  completed-operation counters.

Function
REQ-013 FSM states: IDLE, WR, WR_UPD, RD, RD_UPD, ERR.
REQ-014 All datapath controls, acks, errors and busy are Moore outputs decoded from the state register only.
REQ-015 IDLE with push_req=1 and overflow=0 goes to WR; IDLE with pop_req=1 and underflow=0 goes to RD.
REQ-016 If both requests are serviceable in IDLE, the one not served last goes first, tracked by a 1-bit last_op register (reset 0 = push last, so pop wins first).
REQ-017 IDLE with push_req=1 and overflow=1 goes to ERR and pulses push_err; pop_req=1 with underflow=1 goes to ERR and pulses pop_err; a serviceable request takes priority over an error.
REQ-018 WR outputs: we=1, op_select=0; all other controls 0; next state is WR_UPD.
REQ-019 WR_UPD outputs: add=1, update=1, op_select=0, push_ack=1; push_count increments; next state is IDLE.
REQ-020 RD outputs: re=1, op_select=1; next state is RD_UPD.
REQ-021 RD_UPD outputs: remove=1, update=1, op_select=1, pop_ack=1; pop_count increments; next state is IDLE.
REQ-022 ERR lasts one cycle with all datapath controls 0, then returns to IDLE.
REQ-023 Latency: an accepted operation acks in the 2nd cycle after IDLE samples the request; busy is high for 2 cycles.
REQ-024 A request still high in IDLE after its ack is treated as a new request; this is intentional back-to-back throughput of one operation per 3 cycles.
REQ-025 Request inputs are ignored outside IDLE, and a request dropped mid-operation does not abort it.
REQ-026 Status flags are sampled only in IDLE, one cycle after the previous *_UPD, so updated counts are seen.
REQ-027 Statistics counters wrap modulo 2^CNT_WIDTH without saturating.
REQ-028 we and re are never high in the same cycle, and add and remove are never high in the same cycle.

Reset
REQ-029 rst=1 immediately forces state IDLE, last_op=0 and push_count=pop_count=0, so every output is 0.
REQ-030 Reset during WR or RD abandons the operation with no add/remove/update issued and no ack.
REQ-031 The first transition after reset release occurs on the first rising edge with rst=0.

Structure
REQ-032 The state encoding constants (IDLE=0, WR=1, WR_UPD=2, RD=3, RD_UPD=4, ERR=5, 3 bits) live in shared package queue_pkg, reused by the top-level queue wrapper and the bench.
REQ-033 There is no sub-module: the FSM, last_op and the two counters are inline.
REQ-034 The block connects port-for-port to the datapath's add/remove/update/op_select/we/re/underflow/overflow.

Verification
REQ-035 Reset, then push_req held high for 1 cycle from IDLE: WR then WR_UPD with add=update=push_ack=1, push_count=1, busy high for exactly 2 cycles.
REQ-036 Starting empty (underflow=1), pop_req=1: ERR with pop_err pulse, no re/remove/update, pop_count=0.
REQ-037 With overflow=1, push_req=1: push_err pulse and tail untouched; then pop_req=1 with overflow=0: RD, RD_UPD, pop_ack, pop_count=1.
REQ-038 With both requests held high and the queue non-empty and non-full: service order pop, push, pop, push, ...; acks alternate every 3 cycles.
REQ-039 Assert rst during RD: outputs drop to 0 asynchronously, no remove or pop_ack; after release the FSM is in IDLE.
REQ-040 Drive 256 accepted pushes with CNT_WIDTH=8: push_count wraps to 0, and we&re or add&remove is never seen high together (assertion checks).

Source files
------------

// File: rtl/queue_controller_pkg.sv
// Shared definitions for the queue controller FSM, its wrapper and its bench.
package queue_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        WR_UPD = 3'd2,
        RD     = 3'd3,
        RD_UPD = 3'd4,
        ERR    = 3'd5
    } state_e;

    // Encoding of the last_op arbitration bit.
    localparam logic LAST_PUSH = 1'b0;
    localparam logic LAST_POP  = 1'b1;

endpackage

// File: rtl/queue_controller_if.sv
// Request/ack handshake plus datapath control and status bundle of the queue controller.
interface queue_controller_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 push_req;
    logic                 pop_req;
    logic                 underflow;
    logic                 overflow;
    logic                 add;
    logic                 remove;
    logic                 update;
    logic                 op_select;
    logic                 we;
    logic                 re;
    logic                 push_ack;
    logic                 pop_ack;
    logic                 push_err;
    logic                 pop_err;
    logic                 busy;
    logic [CNT_WIDTH-1:0] push_count;
    logic [CNT_WIDTH-1:0] pop_count;

    // Requester / datapath side.
    modport master (
        output push_req, pop_req, underflow, overflow,
        input  add, remove, update, op_select, we, re,
        input  push_ack, pop_ack, push_err, pop_err, busy, push_count, pop_count
    );

    // Controller side.
    modport slave (
        input  push_req, pop_req, underflow, overflow,
        output add, remove, update, op_select, we, re,
        output push_ack, pop_ack, push_err, pop_err, busy, push_count, pop_count
    );

endinterface

// File: rtl/queue_controller.sv
// Moore FSM sequencing queue push/pop operations onto the datapath, with
// fair push/pop arbitration and wrapping completion counters.
module queue_controller
    import queue_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    queue_controller_if.slave bus
);

    state_e               state_q, state_d;
    logic                 last_op_q, last_op_d;
    logic [1:0]           err_q, err_d;          // {push_err, pop_err} shown while in ERR
    logic [CNT_WIDTH-1:0] push_count_q, push_count_d;
    logic [CNT_WIDTH-1:0] pop_count_q, pop_count_d;
    logic                 push_ok, pop_ok;

    assign push_ok = bus.push_req && !bus.overflow;
    assign pop_ok  = bus.pop_req  && !bus.underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_op_q    <= LAST_PUSH;
            err_q        <= 2'b00;
            push_count_q <= '0;
            pop_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_op_q    <= last_op_d;
            err_q        <= err_d;
            push_count_q <= push_count_d;
            pop_count_q  <= pop_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_op_d    = last_op_q;
        err_d        = err_q;
        push_count_d = push_count_q;
        pop_count_d  = pop_count_q;
        case (state_q)
            IDLE: begin
                // Serviceable requests beat errors; ties go to whichever op did not run last.
                if (push_ok && pop_ok) begin
                    if (last_op_q == LAST_PUSH) begin
                        state_d   = RD;
                        last_op_d = LAST_POP;
                    end else begin
                        state_d   = WR;
                        last_op_d = LAST_PUSH;
                    end
                end else if (push_ok) begin
                    state_d   = WR;
                    last_op_d = LAST_PUSH;
                end else if (pop_ok) begin
                    state_d   = RD;
                    last_op_d = LAST_POP;
                end else if (bus.push_req || bus.pop_req) begin
                    state_d = ERR;
                    err_d   = {bus.push_req, bus.pop_req};
                end
            end
            WR:     state_d = WR_UPD;
            WR_UPD: begin
                state_d      = IDLE;
                push_count_d = push_count_q + 1'b1;
            end
            RD:     state_d = RD_UPD;
            RD_UPD: begin
                state_d     = IDLE;
                pop_count_d = pop_count_q + 1'b1;
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.add       = 1'b0;
        bus.remove    = 1'b0;
        bus.update    = 1'b0;
        bus.op_select = 1'b0;
        bus.we        = 1'b0;
        bus.re        = 1'b0;
        bus.push_ack  = 1'b0;
        bus.pop_ack   = 1'b0;
        bus.push_err  = 1'b0;
        bus.pop_err   = 1'b0;
        bus.busy      = (state_q != IDLE);
        case (state_q)
            WR: bus.we = 1'b1;
            WR_UPD: begin
                bus.add      = 1'b1;
                bus.update   = 1'b1;
                bus.push_ack = 1'b1;
            end
            RD: begin
                bus.re        = 1'b1;
                bus.op_select = 1'b1;
            end
            RD_UPD: begin
                bus.remove    = 1'b1;
                bus.update    = 1'b1;
                bus.op_select = 1'b1;
                bus.pop_ack   = 1'b1;
            end
            ERR: begin
                bus.push_err = err_q[1];
                bus.pop_err  = err_q[0];
            end
            default: ;
        endcase
    end

    assign bus.push_count = push_count_q;
    assign bus.pop_count  = pop_count_q;

endmodule

// File: tb/tb_queue_controller.sv
// Randomized scoreboard bench for queue_controller against a transaction-level model.
module tb_queue_controller;
    import queue_pkg::*;

    localparam int CW  = 8;
    localparam int CAP = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    queue_controller_if #(.CNT_WIDTH(CW)) qif ();

    queue_controller #(.CNT_WIDTH(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (qif.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Datapath stand-in: an occupancy counter driven by the DUT's add/remove.
    int occ = 0;
    assign qif.underflow = (occ == 0);
    assign qif.overflow  = (occ == CAP);
    always @(posedge clk) begin
        if (qif.add)    occ <= occ + 1;
        if (qif.remove) occ <= occ - 1;
    end

    // Reference model: each accepted op occupies 2 cycles, each error 1 cycle.
    typedef struct {
        int kind;   // 0 push ack, 1 pop ack, 2 error
        bit perr;
        bit pderr;
        int cnt;
    } exp_t;
    exp_t sb[$];

    int  m_left  = 0;
    int  m_mode  = 0;
    bit  m_perr  = 0;
    bit  m_pderr = 0;
    bit  m_last  = LAST_PUSH;
    int  m_occ   = 0;
    int  m_npush = 0;
    int  m_npop  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_last = LAST_PUSH; m_npush = 0; m_npop = 0;
            sb.delete();
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_mode == 0) begin m_npush++; m_occ++; end
            if (m_left == 0 && m_mode == 1) begin m_npop++;  m_occ--; end
        end else begin
            bit sp, so;
            exp_t e;
            sp = qif.push_req && (m_occ != CAP);
            so = qif.pop_req  && (m_occ != 0);
            if (sp && so) m_mode = (m_last == LAST_PUSH) ? 1 : 0;
            else if (sp)  m_mode = 0;
            else if (so)  m_mode = 1;
            else          m_mode = 2;
            if (sp || so) begin
                m_last = (m_mode == 1) ? LAST_POP : LAST_PUSH;
                m_left = 2;
                e.kind = m_mode; e.perr = 0; e.pderr = 0;
                e.cnt  = (m_mode == 0) ? m_npush : m_npop;
                sb.push_back(e);
            end else if (qif.push_req || qif.pop_req) begin
                m_left = 1; m_perr = qif.push_req; m_pderr = qif.pop_req;
                e.kind = 2; e.perr = m_perr; e.pderr = m_pderr; e.cnt = 0;
                sb.push_back(e);
            end
        end
    end

    // {add,remove,update,op_select,we,re,push_ack,pop_ack,push_err,pop_err,busy}
    function automatic logic [10:0] exp_vec();
        if (m_left == 0) return 11'b0;
        if (m_mode == 0) return (m_left == 2) ? 11'b00001000001 : 11'b10100010001;
        if (m_mode == 1) return (m_left == 2) ? 11'b00010100001 : 11'b01110001001;
        return {8'b0, m_perr, m_pderr, 1'b1};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {qif.add, qif.remove, qif.update, qif.op_select, qif.we, qif.re,
                qif.push_ack, qif.pop_ack, qif.push_err, qif.pop_err, qif.busy};
    endfunction

    // Monitor: per-cycle output check plus scoreboard pop on every ack/err pulse.
    always @(negedge clk) begin
        if (!rst) begin
            chk("outputs", 32'(dut_vec()), 32'(exp_vec()));
            chk("we_and_re", 32'(qif.we & qif.re), 0);
            chk("add_and_remove", 32'(qif.add & qif.remove), 0);
            if (qif.push_ack || qif.pop_ack || qif.push_err || qif.pop_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'(dut_vec()), 0);
                end else begin
                    exp_t e;
                    int   k;
                    e = sb.pop_front();
                    k = qif.push_ack ? 0 : (qif.pop_ack ? 1 : 2);
                    chk("sb_kind", k, e.kind);
                    if (e.kind == 0) chk("sb_push_count", 32'(qif.push_count), 32'(e.cnt % 256));
                    if (e.kind == 1) chk("sb_pop_count", 32'(qif.pop_count), 32'(e.cnt % 256));
                    if (e.kind == 2) chk("sb_err_flags", {qif.push_err, qif.pop_err}, {e.perr, e.pderr});
                end
            end
        end
    end

    task automatic wait_sig(input string nm, input int which, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            case (which)
                0: seen = qif.push_ack;
                1: seen = qif.pop_ack;
                2: seen = qif.push_err;
                3: seen = qif.pop_err;
                default: seen = !qif.busy;
            endcase
        end
        chk(nm, 32'(seen), 1);
    endtask

    initial begin
        int occ_before;
        qif.push_req = 1'b0;
        qif.pop_req  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(dut_vec()), 0);
        chk("reset_push_count", 32'(qif.push_count), 0);
        chk("reset_pop_count", 32'(qif.pop_count), 0);
        rst = 1'b0;

        // Pop on an empty queue is rejected.
        qif.pop_req = 1'b1;
        wait_sig("empty_pop_err", 3, 10);
        qif.pop_req = 1'b0;
        @(negedge clk);
        chk("empty_pop_count", 32'(qif.pop_count), 0);

        // Single push completes and counts.
        qif.push_req = 1'b1;
        wait_sig("first_push_ack", 0, 10);
        qif.push_req = 1'b0;
        @(negedge clk);
        chk("first_push_count", 32'(qif.push_count), 1);

        // Random level requests, held until ack/err with occasional early drops.
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (qif.push_req) begin
                if ((qif.push_ack || qif.push_err) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 99) < 3))
                    qif.push_req = 1'b0;
            end else if ($urandom_range(0, 99) < 40) qif.push_req = 1'b1;
            if (qif.pop_req) begin
                if ((qif.pop_ack || qif.pop_err) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 99) < 3))
                    qif.pop_req = 1'b0;
            end else if ($urandom_range(0, 99) < 35) qif.pop_req = 1'b1;
        end
        qif.push_req = 1'b0;
        qif.pop_req  = 1'b0;
        wait_sig("drain_idle", 4, 10);
        chk("final_push_count", 32'(qif.push_count), 32'(m_npush % 256));
        chk("final_pop_count", 32'(qif.pop_count), 32'(m_npop % 256));
        chk("occupancy", occ, m_occ);

        // Reset asserted while a pop is in RD.
        if (occ == 0) begin
            qif.push_req = 1'b1;
            wait_sig("pre_reset_push", 0, 10);
            qif.push_req = 1'b0;
            @(negedge clk);
        end
        occ_before = occ;
        qif.pop_req = 1'b1;
        @(posedge clk);
        #1 chk("rd_re", 32'(qif.re), 1);
        #1 rst = 1'b1;
        #1 chk("async_reset_outputs", 32'(dut_vec()), 0);
        qif.pop_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", 32'(qif.busy), 0);
        chk("post_reset_pop_count", 32'(qif.pop_count), 0);
        chk("no_remove_on_reset", occ, occ_before);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
